// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic matmul tile.
// Holds the control FSM encoding, default geometry and the result saturation helper.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPUTE = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int DEF_ROWS       = 4;
    localparam int DEF_COLS       = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_ACC_WIDTH  = 32;
    localparam int DEF_K_WIDTH    = 8;

    // Saturation is evaluated at this width, so accumulators up to 64 bits are supported.
    localparam int SAT_CALC_WIDTH = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_to_width(
        input logic signed [SAT_CALC_WIDTH-1:0] v,
        input int                               dw
    );
        logic signed [SAT_CALC_WIDTH-1:0] hi;
        logic signed [SAT_CALC_WIDTH-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/systolic_matmul_tile_pe.sv
// One processing element: registered right/down operand pass-through plus a
// fixed-point shift-and-accumulate register that is cleared at job start.
module systolic_pe_acc
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc_next
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] prod_sh;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH-1:0] acc;

    // acc_next is exported so the output stage can capture a row on the very
    // edge where its last product lands.
    always_comb begin
        prod     = PW'($signed(a_in)) * PW'($signed(b_in));
        prod_sh  = prod >>> FRAC_BITS;
        addend   = ACC_WIDTH'(prod_sh);
        acc_next = clr ? '0 : acc + addend;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc_next;
        end
    end

endmodule

// File: rtl/systolic_matmul_tile.sv
// Output-stationary ROWS x COLS systolic tile: skews streamed A columns / B rows
// into the PE grid, then drains saturated result rows over a valid/ready port.
module systolic_matmul_tile
    import systolic_pkg::*;
#(
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int K_WIDTH    = DEF_K_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [K_WIDTH-1:0]              k_len,
    output logic                            busy,
    output logic                            done,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]      in_a,
    input  logic [COLS*DATA_WIDTH-1:0]      in_b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [idx_width(ROWS)-1:0]      out_row,
    output logic [COLS*DATA_WIDTH-1:0]      out_data
);

    localparam int DW        = DATA_WIDTH;
    localparam int RW        = idx_width(ROWS);
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FW        = idx_width(FLUSH_LEN);

    localparam logic [RW-1:0]      LAST_ROW   = RW'(ROWS - 1);
    localparam logic [FW-1:0]      FLUSH_LAST = FW'(FLUSH_LEN - 1);
    localparam logic [K_WIDTH-1:0] K_ONE      = K_WIDTH'(1);

    state_t state;
    state_t state_nxt;

    logic [K_WIDTH-1:0] k_rem;
    logic [FW-1:0]      flush_cnt;
    logic               accept;
    logic               out_fire;
    logic               clr_acc;

    logic [DW-1:0]        a_edge   [ROWS];
    logic [DW-1:0]        b_edge   [COLS];
    logic [DW-1:0]        a_pass   [ROWS][COLS];
    logic [DW-1:0]        b_pass   [ROWS][COLS];
    logic [ACC_WIDTH-1:0] acc_next [ROWS][COLS];

    logic [RW-1:0]         row_sel;
    logic [COLS*DW-1:0]    sat_row;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. in_ready/out_valid depend only on registered state, never on
    // the partner's valid/ready, and out_row/out_data hold while stalled.
    assign accept   = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (k_len == '0) ? ST_FLUSH : ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (accept && (k_rem == K_ONE)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && (out_row == LAST_ROW)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        in_ready  = (state == ST_COMPUTE) && (k_rem != '0);
        out_valid = (state == ST_DRAIN);
        clr_acc   = (state == ST_IDLE) && start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_rem     <= '0;
            flush_cnt <= '0;
        end else begin
            if (clr_acc) begin
                k_rem <= k_len;
            end else if (accept) begin
                k_rem <= k_rem - K_ONE;
            end
            if (state == ST_FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end else begin
                flush_cnt <= '0;
            end
        end
    end

    // Lane i of A passes through i+1 registers so it meets B lane j at PE(i,j)
    // one cycle per hop later; non-accepted cycles inject zero bubbles.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic [DW-1:0] sr [0:gi];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= gi; s++) begin
                    sr[s] <= '0;
                end
            end else begin
                sr[0] <= accept ? in_a[gi*DW +: DW] : '0;
                for (int s = 1; s <= gi; s++) begin
                    sr[s] <= sr[s-1];
                end
            end
        end
        assign a_edge[gi] = sr[gi];
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_b_skew
        logic [DW-1:0] sr [0:gj];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= gj; s++) begin
                    sr[s] <= '0;
                end
            end else begin
                sr[0] <= accept ? in_b[gj*DW +: DW] : '0;
                for (int s = 1; s <= gj; s++) begin
                    sr[s] <= sr[s-1];
                end
            end
        end
        assign b_edge[gj] = sr[gj];
    end

    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            logic [DW-1:0] a_src;
            logic [DW-1:0] b_src;

            if (gc == 0) begin : g_a_from_edge
                assign a_src = a_edge[gr];
            end else begin : g_a_from_left
                assign a_src = a_pass[gr][gc-1];
            end

            if (gr == 0) begin : g_b_from_edge
                assign b_src = b_edge[gc];
            end else begin : g_b_from_above
                assign b_src = b_pass[gr-1][gc];
            end

            systolic_pe_acc #(
                .DATA_WIDTH (DATA_WIDTH),
                .FRAC_BITS  (FRAC_BITS),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk      (clk),
                .rst      (rst),
                .clr      (clr_acc),
                .a_in     (a_src),
                .b_in     (b_src),
                .a_out    (a_pass[gr][gc]),
                .b_out    (b_pass[gr][gc]),
                .acc_next (acc_next[gr][gc])
            );
        end
    end

    // Row captured on the next output-register update: row 0 when leaving
    // FLUSH, otherwise the row following the one being accepted.
    always_comb begin
        row_sel = '0;
        if ((state != ST_FLUSH) && (out_row != LAST_ROW)) begin
            row_sel = out_row + 1'b1;
        end
        sat_row = '0;
        for (int j = 0; j < COLS; j++) begin
            sat_row[j*DW +: DW] =
                DW'(sat_to_width(SAT_CALC_WIDTH'($signed(acc_next[row_sel][j])), DW));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_row  <= '0;
            out_data <= '0;
        end else if ((state == ST_FLUSH) && (state_nxt == ST_DRAIN)) begin
            out_row  <= '0;
            out_data <= sat_row;
        end else if (out_fire) begin
            if (out_row == LAST_ROW) begin
                out_row  <= '0;
                out_data <= '0;
            end else begin
                out_row  <= out_row + 1'b1;
                out_data <= sat_row;
            end
        end
    end

endmodule

// File: doc/systolic_matmul_tile.md
Name: systolic_matmul_tile

Overview:
- Parametrised output-stationary systolic tile computing C[ROWS×COLS] = A[ROWS×K]·B[K×COLS] in signed fixed point.
- Adds to the existing fixed 8×8 kernel:
  - on-chip input skewing
  - run-time K length
  - start/busy/done control
  - valid/ready streaming in and out
  - a wide accumulator with saturating output
- Sits between the operand buffers and the result writeback of the accelerator datapath.

Parameters:
- ROWS, 4, PE rows; number of A lanes per beat.
- COLS, 4, PE columns; number of B lanes per beat.
- DATA_WIDTH, 16, signed operand/result width.
- FRAC_BITS, 8, fractional bits; product arithmetic-shifted right by this amount.
- ACC_WIDTH, 32, signed accumulator width (≥ DATA_WIDTH).
- K_WIDTH, 8, width of k_len.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  job start pulse; sampled only in IDLE.
- k_len  in  K_WIDTH  number of operand beats for the job; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result beat is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in COMPUTE while beats remain.
- in_a  in  ROWS*DATA_WIDTH  column k of A; lane i at [i*DW +: DW].
- in_b  in  COLS*DATA_WIDTH  row k of B; lane j at [j*DW +: DW].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accept.
- out_row  out  $clog2(ROWS) (min 1)  index of the row presented.
- out_data  out  COLS*DATA_WIDTH  saturated C[out_row][*]; lane j at [j*DW +: DW].

Behaviour:
- Reset (async, any state): FSM→IDLE; all counters, skew registers, PE pass registers and accumulators cleared. busy=0, done=0, in_ready=0, out_valid=0, out_row=0, out_data=0.
- FSM states: IDLE, COMPUTE, FLUSH, DRAIN, DONE.
  - IDLE: start=1 → clear accumulators, latch k_len. Next state is COMPUTE, or FLUSH if k_len=0.
  - COMPUTE: beat accepted when in_valid&in_ready. After the k_len-th accepted beat → FLUSH.
  - FLUSH: lasts exactly ROWS+COLS-1 cycles → DRAIN.
  - DRAIN: presents rows 0..ROWS-1 in order. Row advances on out_valid&out_ready. Acceptance of row ROWS-1 → DONE.
  - DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored.
- Array advances every cycle regardless of in_valid.
  - In any cycle without an accepted beat, zeros enter all lanes (bubbles).
  - Bubbles contribute nothing, so gaps in in_valid do not change results.
- Skew/latency for a beat accepted at edge c:
  - A lane i reaches PE(i,0) during cycle c+1+i; B lane j reaches PE(0,j) during cycle c+1+j.
  - PE(i,j) accumulates that pair at the end of cycle c+1+i+j.
  - Last PE completes at end of cycle c+ROWS+COLS-1, hence the FLUSH length.
- PE arithmetic:
  - product = a*b, full 2*DATA_WIDTH signed.
  - Arithmetic shift right by FRAC_BITS (floor rounding).
  - Sign-extend to ACC_WIDTH and add to the accumulator.
  - Accumulator wraps modulo 2^ACC_WIDTH; no overflow flag.
- Output: each lane saturates to [-2^(DW-1), 2^(DW-1)-1].
- out_data and out_row are registered and held stable while out_valid&!out_ready.
- out_valid is high only in DRAIN; in_ready is never high outside COMPUTE.

Decomposition:
- Package systolic_pkg holds:
  - FSM state enum
  - sat_to_width function (ACC_WIDTH→DATA_WIDTH saturation)
  - the lane slicing width constants
- Sub-module systolic_pe_acc: one PE with registered down/right pass-through, clear input, and shift-and-accumulate. It is instantiated ROWS×COLS via generate.
- Skew delay lines and the FSM stay in the top module.

Test Plan:
- Identity: ROWS=COLS=4, FRAC_BITS=8, k_len=4, A=256·I, B[k][j]=256·(k*4+j) → row r out_data lane j = 256·(r*4+j). done pulses once and busy falls the same cycle.
- Bubbles: same job with in_valid toggled every other cycle plus a 5-cycle gap → bit-identical results. in_ready drops after exactly 4 accepted beats.
- Saturation: k_len=1, all in_a=in_b=0x7F00 → all outputs 0x7FFF. With in_b=0x8100 → all outputs 0x8000.
- Backpressure: hold out_ready=0 for 3 cycles on row 1 → out_valid stays 1 with out_row=1 and data stable. Release → rows 2,3 follow, then done.
- Empty job: k_len=0 → no in_ready, FLUSH 7 cycles, 4 rows of zeros drained, done pulse. start asserted during DRAIN is ignored.
- Reset mid-job: assert rst after 2 of 4 beats → all outputs zero immediately. A new identity job after release returns correct results with no residue from the aborted job.
